// File: rtl/rs_pipe_addsub.sv
// -----------------------------------------------------------------------------
// rs_pipe_addsub
//
// Pipelined wide adder/subtractor. The operands are cut into SEG-bit carry
// chain segments and each segment is resolved in its own pipeline stage. The
// carry out of a segment is registered and handed to the next stage together
// with the not-yet-used operand bits, so the longest combinational carry chain
// is SEG bits no matter how wide the operands are. The whole pipe advances as
// one unit under a single valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (depends only on out_valid/out_ready)
//   a, b       WIDTH-bit operands
//   ci         carry into bit 0
//   sub        invert b before the add (caller sets ci=1 for a true subtract)
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   y          a + (sub ? ~b : b) + ci, modulo 2^WIDTH
//   x          propagate vector a ^ (sub ? ~b : b), aligned with y
//   co         carry out of bit WIDTH-1 (0 on a subtract means borrow)
//   ov         signed overflow, carry into bit WIDTH-1 xor co
//   zero       y == 0
// -----------------------------------------------------------------------------
module rs_pipe_addsub #(
  parameter int WIDTH = 40,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x,
  output logic             co,
  output logic             ov,
  output logic             zero
);

  localparam int NSEG = (WIDTH + SEG - 1) / SEG;

  logic             w_adv;
  logic [WIDTH-1:0] w_bb;

  assign w_bb = sub ? ~b : b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Segment k covers [LO +: W]; only the top segment can be narrower.
    localparam int LO = k * SEG;
    localparam int W  = (k == NSEG - 1) ? (WIDTH - LO) : SEG;

    logic             w_inVld;
    logic [WIDTH-1:0] w_inA;
    logic [WIDTH-1:0] w_inBb;
    logic [WIDTH-1:0] w_inY;
    logic [WIDTH-1:0] w_inX;
    logic             w_inC;
    logic [W:0]       w_segSum;
    logic [WIDTH-1:0] w_nextY;
    logic [WIDTH-1:0] w_nextX;

    logic             r_vld;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_x;

    // Stage 0 is fed straight from the ports; later stages take the operands,
    // partial results and carry that the previous stage registered for the
    // same beat.
    if (k == 0) begin : g_src
      assign w_inVld = in_valid;
      assign w_inA   = a;
      assign w_inBb  = w_bb;
      assign w_inY   = '0;
      assign w_inX   = '0;
      assign w_inC   = ci;
    end else begin : g_src
      assign w_inVld = g_stage[k-1].r_vld;
      assign w_inA   = g_stage[k-1].g_link.r_a;
      assign w_inBb  = g_stage[k-1].g_link.r_bb;
      assign w_inY   = g_stage[k-1].r_y;
      assign w_inX   = g_stage[k-1].r_x;
      assign w_inC   = g_stage[k-1].g_link.r_c;
    end

    assign w_segSum = {1'b0, w_inA[LO +: W]} + {1'b0, w_inBb[LO +: W]}
                    + {{W{1'b0}}, w_inC};

    // Splice this stage's segment into the partial sum and propagate vectors
    // that travel with the beat.
    always_comb begin
      w_nextY          = w_inY;
      w_nextX          = w_inX;
      w_nextY[LO +: W] = w_segSum[W-1:0];
      w_nextX[LO +: W] = w_inA[LO +: W] ^ w_inBb[LO +: W];
    end

    // Every stage holds while the output is stalled, which keeps each beat's
    // registered carry paired with that beat's operands.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_y   <= '0;
        r_x   <= '0;
      end else if (w_adv) begin
        r_vld <= w_inVld;
        r_y   <= w_nextY;
        r_x   <= w_nextX;
      end
    end

    if (k < NSEG - 1) begin : g_link
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_bb;
      logic             r_c;

      // Operands and segment carry handed on to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a  <= '0;
          r_bb <= '0;
          r_c  <= 1'b0;
        end else if (w_adv) begin
          r_a  <= w_inA;
          r_bb <= w_inBb;
          r_c  <= w_segSum[W];
        end
      end
    end else begin : g_tail
      logic w_carryMsb;
      logic r_co;
      logic r_ov;
      logic r_zero;

      // The carry into the MSB is recovered from the MSB sum bit and its two
      // operand bits, avoiding a separate split of the top-segment adder.
      assign w_carryMsb = w_segSum[W-1] ^ w_inA[WIDTH-1] ^ w_inBb[WIDTH-1];

      // Flags are registered together with the final y/x.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_co   <= 1'b0;
          r_ov   <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_co   <= w_segSum[W];
          r_ov   <= w_carryMsb ^ w_segSum[W];
          r_zero <= (w_nextY == '0);
        end
      end
    end
  end

  // The pipe moves as a whole whenever the output register is free or drained.
  assign w_adv     = !g_stage[NSEG-1].r_vld || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = g_stage[NSEG-1].r_vld;
  assign y         = g_stage[NSEG-1].r_y;
  assign x         = g_stage[NSEG-1].r_x;
  assign co        = g_stage[NSEG-1].g_tail.r_co;
  assign ov        = g_stage[NSEG-1].g_tail.r_ov;
  assign zero      = g_stage[NSEG-1].g_tail.r_zero;

endmodule

// File: tb/tb_rs_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_rs_pipe_addsub
//
// Bench for rs_pipe_addsub. A 40/16 instance runs directed vectors and a
// mid-flight reset. Five further instances ((8,8), (17,16), (64,16), (33,4),
// (40,16)) each measure latency and run a randomized stream with a toggling
// out_ready against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_rs_pipe_addsub;

  localparam int WIDTH = 40;
  localparam int SEG   = 16;
  localparam int NSEG  = 3;
  localparam int BEATS = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic             co;
  logic             ov;
  logic             zero;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  rs_pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .x         (x),
    .co        (co),
    .ov        (ov),
    .zero      (zero)
  );

  typedef struct packed {
    logic [63:0] y;
    logic [63:0] x;
    logic        co;
    logic        ov;
    logic        zero;
  } result_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             ci;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] x;
    logic             co;
    logic             ov;
    logic             zero;
  } vec_t;

  // Reference: plain modular arithmetic; overflow from the sign rule
  // (same-signed operands giving a differently-signed result).
  function automatic result_t modelResult(input logic [63:0] aIn, input logic [63:0] bIn,
                                          input logic subIn, input logic ciIn, input int w);
    result_t     r;
    logic [64:0] mask;
    logic [64:0] aa;
    logic [64:0] bb;
    logic [64:0] sum;
    mask   = (65'd1 << w) - 65'd1;
    aa     = {1'b0, aIn} & mask;
    bb     = (subIn ? ~{1'b0, bIn} : {1'b0, bIn}) & mask;
    sum    = aa + bb + {64'd0, ciIn};
    r.y    = sum[63:0] & mask[63:0];
    r.x    = aa[63:0] ^ bb[63:0];
    r.co   = sum[w];
    r.ov   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    r.zero = (r.y == 64'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers a single beat on an empty pipe (also releasing reset on the same
  // negedge) and returns how many edges it took, counting the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                               input logic subI, input logic ciI, output int edges);
    @(negedge clk);
    a         = ai;
    b         = bi;
    sub       = subI;
    ci        = ciI;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sweep instances with randomized streams.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 5; gi++) begin : g_cfg
    localparam int CW = (gi == 0) ? 8 : (gi == 1) ? 17 : (gi == 2) ? 64 : (gi == 3) ? 33 : 40;
    localparam int CS = (gi == 0) ? 8 : (gi == 1) ? 16 : (gi == 2) ? 16 : (gi == 3) ? 4  : 16;
    localparam int CN = (gi == 0) ? 1 : (gi == 1) ? 2  : (gi == 2) ? 4  : (gi == 3) ? 9  : 3;

    logic          sRst;
    logic          sInValid;
    logic          sInReady;
    logic          sCi;
    logic          sSub;
    logic          sOutValid;
    logic          sOutReady;
    logic          sCo;
    logic          sOv;
    logic          sZero;
    logic [CW-1:0] sA;
    logic [CW-1:0] sB;
    logic [CW-1:0] sY;
    logic [CW-1:0] sX;
    logic          done;

    rs_pipe_addsub #(.WIDTH(CW), .SEG(CS)) u_dut (
      .clk       (clk),
      .rst       (sRst),
      .in_valid  (sInValid),
      .in_ready  (sInReady),
      .a         (sA),
      .b         (sB),
      .ci        (sCi),
      .sub       (sSub),
      .out_valid (sOutValid),
      .out_ready (sOutReady),
      .y         (sY),
      .x         (sX),
      .co        (sCo),
      .ov        (sOv),
      .zero      (sZero)
    );

    initial begin
      result_t       q[$];
      result_t       e;
      logic [63:0]   r1;
      logic [63:0]   r2;
      logic [CW-1:0] heldY;
      logic [CW-1:0] heldX;
      logic          held;
      logic          accepted;
      int            lat;
      int            sent;
      int            got;
      int            cyc;
      string         tag;

      tag       = $sformatf("cfg(%0d,%0d)", CW, CS);
      done      = 1'b0;
      sRst      = 1'b1;
      sInValid  = 1'b0;
      sOutReady = 1'b0;
      sA        = '0;
      sB        = '0;
      sSub      = 1'b0;
      sCi       = 1'b0;
      repeat (2) @(negedge clk);

      // Latency probe on an empty pipe.
      r1        = {$urandom, $urandom};
      r2        = {$urandom, $urandom};
      sA        = r1[CW-1:0];
      sB        = r2[CW-1:0];
      sSub      = 1'b0;
      sCi       = 1'b1;
      sInValid  = 1'b1;
      sOutReady = 1'b1;
      sRst      = 1'b0;
      e         = modelResult(64'(sA), 64'(sB), 1'b0, 1'b1, CW);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      sInValid = 1'b0;
      while (!sOutValid && lat < 30) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      checkOutput({tag, " latency"}, 64'(lat), 64'(CN));
      checkOutput({tag, " probe y"}, 64'(sY), e.y);
      @(negedge clk);

      // Random stream with random bubbles and a random out_ready pattern.
      sent     = 0;
      got      = 0;
      cyc      = 0;
      held     = 1'b0;
      accepted = 1'b0;
      heldY    = '0;
      heldX    = '0;
      while (got < BEATS && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        if (accepted) sInValid = 1'b0;
        if (!sInValid && sent < BEATS && $urandom_range(0, 4) != 0) begin
          r1       = {$urandom, $urandom};
          r2       = {$urandom, $urandom};
          sA       = r1[CW-1:0];
          sB       = r2[CW-1:0];
          sSub     = 1'($urandom_range(0, 1));
          sCi      = 1'($urandom_range(0, 1));
          sInValid = 1'b1;
        end
        sOutReady = ($urandom_range(0, 3) != 0);
        #1;
        checkOutput({tag, " in_ready"}, 64'(sInReady), 64'(!(sOutValid && !sOutReady)));
        if (held) begin
          checkOutput({tag, " stall hold y"}, 64'(sY), 64'(heldY));
          checkOutput({tag, " stall hold x"}, 64'(sX), 64'(heldX));
        end
        if (sOutValid && sOutReady) begin
          if (q.size() == 0) begin
            checkOutput({tag, " spurious out_valid"}, 64'(sOutValid), 64'd0);
          end else begin
            e = q.pop_front();
            checkOutput({tag, " y"},    64'(sY),    e.y);
            checkOutput({tag, " x"},    64'(sX),    e.x);
            checkOutput({tag, " co"},   64'(sCo),   64'(e.co));
            checkOutput({tag, " ov"},   64'(sOv),   64'(e.ov));
            checkOutput({tag, " zero"}, 64'(sZero), 64'(e.zero));
          end
          got++;
        end
        held  = sOutValid && !sOutReady;
        heldY = sY;
        heldX = sX;
        accepted = sInValid && sInReady;
        if (accepted) begin
          q.push_back(modelResult(64'(sA), 64'(sB), sSub, sCi, CW));
          sent++;
        end
      end
      checkOutput({tag, " beats delivered"}, 64'(got), 64'(BEATS));
      sInValid = 1'b0;
      done     = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors, mid-flight reset, and the summary.
  // ---------------------------------------------------------------------------
  initial begin
    vec_t vecs[6];
    int   lat;
    int   cyc;

    vecs[0] = '{40'hFF_FFFF_FFFF, 40'd1, 1'b0, 1'b0, 40'h00_0000_0000, 40'hFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{40'h7F_FFFF_FFFF, 40'd1, 1'b0, 1'b0, 40'h80_0000_0000, 40'h7F_FFFF_FFFE, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{40'd5,            40'd7, 1'b1, 1'b1, 40'hFF_FFFF_FFFE, 40'hFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{40'd7,            40'd5, 1'b1, 1'b1, 40'h00_0000_0002, 40'hFF_FFFF_FFFD, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{40'd0,            40'd0, 1'b1, 1'b1, 40'h00_0000_0000, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{40'h80_0000_0000, 40'd1, 1'b1, 1'b1, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFE, 1'b1, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    ci        = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset y",         64'(y),         64'd0);
    checkOutput("reset x",         64'(x),         64'd0);
    checkOutput("reset co",        64'(co),        64'd0);
    checkOutput("reset ov",        64'(ov),        64'd0);
    checkOutput("reset zero",      64'(zero),      64'd0);
    checkOutput("reset in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].ci, lat);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat),  64'(NSEG));
      checkOutput($sformatf("vec%0d y", i),       64'(y),    64'(vecs[i].y));
      checkOutput($sformatf("vec%0d x", i),       64'(x),    64'(vecs[i].x));
      checkOutput($sformatf("vec%0d co", i),      64'(co),   64'(vecs[i].co));
      checkOutput($sformatf("vec%0d ov", i),      64'(ov),   64'(vecs[i].ov));
      checkOutput($sformatf("vec%0d zero", i),    64'(zero), 64'(vecs[i].zero));
    end

    // Two beats in flight, then reset: everything clears at once and no stale
    // beat may appear ahead of the first post-reset beat.
    @(negedge clk);
    a         = 40'h12_3456_789A;
    b         = 40'h0F_0F0F_0F0F;
    sub       = 1'b0;
    ci        = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    a = 40'h55_5555_5555;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid reset y",         64'(y),         64'd0);
    checkOutput("mid reset x",         64'(x),         64'd0);
    checkOutput("mid reset co",        64'(co),        64'd0);
    checkOutput("mid reset ov",        64'(ov),        64'd0);
    checkOutput("mid reset zero",      64'(zero),      64'd0);
    checkOutput("mid reset in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    applyStimulus(40'h00_0001_FFFF, 40'h00_0000_0001, 1'b0, 1'b0, lat);
    checkOutput("post reset latency", 64'(lat), 64'(NSEG));
    checkOutput("post reset y",       64'(y),   64'h00_0002_0000);
    checkOutput("post reset co",      64'(co),  64'd0);
    @(negedge clk);
    out_ready = 1'b1;

    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done && g_cfg[4].done)
           && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("sweep completion", 64'(cyc < 20000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
